exe_muldiv_seq: RTL
===================

# exe_muldiv_seq

Iterative multiply/divide sequencer attached to the execute stage. It implements the RV64M operations MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms. Each operation runs as a multi-cycle shift-add or restoring-divide sequence. While it runs, the block raises a stall request so the pipeline holds the instruction in execute, then presents a one-cycle done with the 64-bit result for capture into the memory stage.

## Interface
- No parameters. Operand/result width is fixed at 64.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  op[2:0] = funct3, with 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. op[3] = word (W) form.
- rs1  in  64  operand 1, already forwarded.
- rs2  in  64  operand 2, already forwarded.
- flush  in  1  abort current or pending operation.
- stall_req  out  1  holds decode/execute stages.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; result valid in this cycle.
- result  out  64  final value; held until the next accepted start.

## Operation
- **States:**
  - IDLE: wait for a request.
  - CALC: 64 iteration cycles.
  - FIX: sign correction and W extension.
  - DONE: done=1.
- **IDLE → CALC** when start=1 and flush=0. The block latches op and the prepared operands, and clears the iteration counter (7 bit).
- **CALC → FIX** after counter reaches 63, i.e. 64 CALC cycles.
- **FIX → DONE**, then **DONE → IDLE**, unconditionally.
- **flush** in CALC, FIX or DONE: return to IDLE at the next edge. done stays 0 and result is not updated.
  - flush has priority over start in IDLE.
- **Operand preparation:**
  - Signed ops (MULH, DIV, REM, signed side of MULHSU) take absolute values and record the signs.
  - W forms: DIVW/REMW sign-extend rs1[31:0]/rs2[31:0]. DIVUW/REMUW zero-extend. MULW uses low 32 bits.
- **Multiply:** 128-bit accumulator, one shift-add per CALC cycle.
  - MUL returns product[63:0].
  - MULH/MULHSU/MULHU return product[127:64] after two's-complement negation when the sign flag is set.
  - op[3] with funct3 001–011 is treated as MULW.
- **Divide:** restoring, one quotient bit per CALC cycle.
  - Quotient sign = s1^s2. Remainder sign = s1.
- **Divide by zero:** quotient = all ones; remainder = dividend (W: extended dividend).
- **Signed overflow** (non-W, rs1=0x8000_0000_0000_0000, rs2=all ones): quotient = rs1, remainder = 0.
  - W form needs no special case: the extended computation yields the correct value.
- **W results:** sign-extended from bit 31 in FIX.
- **stall_req** = (IDLE & start & ~flush) | CALC | FIX. It is deasserted in DONE so the pipeline advances and captures result.

## Timing
- **Reset values:** state IDLE; busy 0, done 0, stall_req 0, result 0, counter 0. Reset asynchronously aborts any operation mid-sequence.
- **Normal op:** start accepted at cycle T.
  - CALC covers T+1..T+64.
  - FIX at T+65.
  - DONE at T+66 (done=1, result valid).
  - IDLE at T+67; a new start may be accepted at T+67.
- start is ignored whenever state != IDLE.
- Operands are only sampled at acceptance; later changes on rs1/rs2/op have no effect.
- result changes only on the FIX → DONE edge.

## Configuration
- MULDIV_EARLY_OUT_EN:
  - **Defined:** divide-by-zero, signed overflow, and multiply with either operand zero go IDLE → FIX directly, giving done at T+2.
  - **Undefined:** every operation takes the full 64 CALC cycles (done at T+66), with identical result values.

## Test plan
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (−3), start at T → done at T+66, result 0xFFFF_FFFF_FFFF_FFEB; stall_req high T..T+65, low at T+66.
- MULHU rs1=rs2=all ones → result 0xFFFF_FFFF_FFFF_FFFE. MULH same operands → 0.
- DIVU 100/0 → all ones. REMU 100/0 → 100 (0x64). DIV 0x8000_0000_0000_0000 / all ones → 0x8000_0000_0000_0000. REM same → 0.
  - With MULDIV_EARLY_OUT_EN: done at T+2. Without: done at T+66.
- DIVW rs1=0xFFFF_FFFF_FFFF_FFF9, rs2=2 → 0xFFFF_FFFF_FFFF_FFFD. REMW same → all ones. DIVUW rs1=0x1_0000_0010, rs2=4 → 4.
- Start DIV, assert flush at T+10 → busy 0 at T+11, done never pulses, result keeps its prior value. Start with flush in the same IDLE cycle → not accepted.
- Assert rst at T+30 of a MUL → busy/stall_req/done/result 0 immediately. After release, a new MUL is accepted and completes correctly 66 cycles later.

Source files
------------

// File: rtl/exe_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv_seq
// Purpose  : Iterative RV64M multiply/divide sequencer (shift-add / restoring).
//            Define MULDIV_EARLY_OUT_EN to skip CALC for trivial operands.
// Revision : 1.0  initial release
// ============================================================================
module exe_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam logic [63:0] C_MIN64 = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       r_state, w_next;
  logic [6:0]   r_cnt;
  logic [3:0]   r_op;
  logic [63:0]  r_dvsr;
  logic [127:0] r_acc;
  logic         r_neg, r_dz;
  logic [63:0]  r_result;

  logic         w_accept, w_is_div, w_w, w_sgn_div;
  logic [63:0]  w_x1, w_x2, w_a1, w_a2;
  logic         w_s1, w_s2, w_neg, w_dz, w_early;
  logic [127:0] w_acc_init, w_acc_step, w_pneg;
  logic [64:0]  w_sum, w_sh, w_diff;
  logic [63:0]  w_q, w_r, w_fix;

  assign w_accept = (r_state == S_IDLE) & start & ~flush;

  // Operand preparation: W extension, magnitudes and result sign.
  always_comb begin
    w_is_div  = op[2];
    w_w       = op[3];
    w_sgn_div = op[2] & ~op[0];
    w_x1      = rs1;
    w_x2      = rs2;
    if (w_w) begin
      if (w_sgn_div) begin
        w_x1 = {{32{rs1[31]}}, rs1[31:0]};
        w_x2 = {{32{rs2[31]}}, rs2[31:0]};
      end else begin
        w_x1 = {32'd0, rs1[31:0]};
        w_x2 = {32'd0, rs2[31:0]};
      end
    end
    if (w_is_div) begin
      w_s1 = w_sgn_div & w_x1[63];
      w_s2 = w_sgn_div & w_x2[63];
    end else begin
      w_s1 = ~w_w & ((op[1:0] == 2'b01) | (op[1:0] == 2'b10)) & w_x1[63];
      w_s2 = ~w_w & (op[1:0] == 2'b01) & w_x2[63];
    end
    w_a1       = w_s1 ? -w_x1 : w_x1;
    w_a2       = w_s2 ? -w_x2 : w_x2;
    w_neg      = (w_is_div & op[1]) ? w_s1 : (w_s1 ^ w_s2);
    w_dz       = w_is_div & (w_x2 == 64'd0);
    w_acc_init = {64'd0, (w_is_div ? w_a1 : w_a2)};
    w_early    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    // Preload the accumulator with what 64 iterations would have produced.
    if (w_dz) begin
      w_early    = 1'b1;
      w_acc_init = {w_a1, {64{1'b1}}};
    end else if (w_sgn_div & ~w_w & (rs1 == C_MIN64) & (rs2 == {64{1'b1}})) begin
      w_early    = 1'b1;
      w_acc_init = {64'd0, C_MIN64};
    end else if (~w_is_div & ((w_a1 == 64'd0) | (w_a2 == 64'd0))) begin
      w_early    = 1'b1;
      w_acc_init = 128'd0;
    end
`endif
  end

  // One iteration: acc = {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    w_sum  = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_dvsr} : 65'd0);
    w_sh   = {r_acc[127:64], r_acc[63]};
    w_diff = w_sh - {1'b0, r_dvsr};
    if (!r_op[2])
      w_acc_step = {w_sum, r_acc[63:1]};
    else if (!w_diff[64])
      w_acc_step = {w_diff[63:0], r_acc[62:0], 1'b1};
    else
      w_acc_step = {w_sh[63:0], r_acc[62:0], 1'b0};
  end

  always_comb begin
    w_pneg = -r_acc;
    w_q    = r_dz ? {64{1'b1}} : (r_neg ? -r_acc[63:0] : r_acc[63:0]);
    w_r    = r_neg ? -r_acc[127:64] : r_acc[127:64];
    if (r_op[2])
      w_fix = r_op[1] ? w_r : w_q;
    else if (r_op[3] | (r_op[1:0] == 2'b00))
      w_fix = r_acc[63:0];
    else
      w_fix = r_neg ? w_pneg[127:64] : r_acc[127:64];
    if (r_op[3])
      w_fix = {{32{w_fix[31]}}, w_fix[31:0]};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_early ? S_FIX : S_CALC;
      S_CALC:  if (flush) w_next = S_IDLE;
               else if (r_cnt == 7'd63) w_next = S_FIX;
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 7'd0;
      r_op     <= 4'd0;
      r_dvsr   <= 64'd0;
      r_acc    <= 128'd0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= op;
          r_dvsr <= w_is_div ? w_a2 : w_a1;
          r_acc  <= w_acc_init;
          r_neg  <= w_neg;
          r_dz   <= w_dz;
          r_cnt  <= 7'd0;
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 7'd1;
        end
        S_FIX:   if (!flush) r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) & ~flush;
  assign stall_req = w_accept | (r_state == S_CALC) | (r_state == S_FIX);
  assign result    = r_result;

endmodule
`default_nettype wire
